// File: rtl/copro_pkg.sv
// Shared types for the coprocessor execution stage: opcodes, FSM states and the
// result record queued back to the core.
package copro_pkg;

  localparam int unsigned XLEN_DEF    = 32;
  localparam int unsigned HARTID_W_DEF = 1;
  localparam int unsigned ID_W_DEF     = 3;

  typedef enum logic [3:0] {
    OP_NOP       = 4'd0,
    OP_ADD       = 4'd1,
    OP_DBL       = 4'd2,
    OP_ADD_MULTI = 4'd3,
    OP_ADD3      = 4'd4
  } opcode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic [HARTID_W_DEF-1:0] hartid;
    logic [ID_W_DEF-1:0]     id;
    logic [XLEN_DEF-1:0]     data;
    logic [4:0]              rd;
    logic                    we;
  } result_t;

endpackage

// File: rtl/copro_result_fifo.sv
// In-order result queue (circular buffer), generic over the entry type; head is
// visible one cycle after the push edge, no full-bypass on simultaneous pop.
module copro_result_fifo #(
  parameter type         T     = logic,
  parameter int unsigned Depth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  T                       push_dat_i,
  input  logic                   pop_i,
  output T                       head_o,
  output logic                   valid_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  T                mem_q [Depth];
  T                mem_d [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            do_push, do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push_i && (count_q < (PtrW+1)'(Depth));
    do_pop   = pop_i && (count_q != '0);
    // Depth is a power of two, so pointer overflow is the wrap.
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/copro_exec_unit.sv
// Coprocessor execute stage: single-cycle ops queue at the accept edge, ADD_MULTI
// after MultiLatency-1 edges; in_ready_o drops while busy or the queue is full.
import copro_pkg::*;

module copro_exec_unit #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned NrRgprPorts  = 2,
  parameter int unsigned HartIdWidth  = 1,
  parameter int unsigned IdWidth      = 3,
  parameter int unsigned FifoDepth    = 4,
  parameter int unsigned MultiLatency = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [3:0]                  opcode_i,
  input  logic [NrRgprPorts*XLEN-1:0] registers_i,
  input  logic [HartIdWidth-1:0]      hartid_i,
  input  logic [IdWidth-1:0]          id_i,
  input  logic [4:0]                  rd_i,
  output logic                        result_valid_o,
  input  logic                        result_ready_i,
  output logic [HartIdWidth-1:0]      result_hartid_o,
  output logic [IdWidth-1:0]          result_id_o,
  output logic [XLEN-1:0]             result_data_o,
  output logic [4:0]                  result_rd_o,
  output logic                        result_we_o
);

  localparam int unsigned CntW  = $clog2(MultiLatency);
  localparam int unsigned FcntW = $clog2(FifoDepth) + 1;

  // Same layout as copro_pkg::result_t, sized by this instance's parameters.
  typedef struct packed {
    logic [HartIdWidth-1:0] hartid;
    logic [IdWidth-1:0]     id;
    logic [XLEN-1:0]        data;
    logic [4:0]             rd;
    logic                   we;
  } exec_result_t;

  typedef struct packed {
    logic [XLEN-1:0]        a;
    logic [XLEN-1:0]        b;
    logic [HartIdWidth-1:0] hartid;
    logic [IdWidth-1:0]     id;
    logic [4:0]             rd;
  } multi_op_t;

  state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  multi_op_t    mop_q, mop_d;

  logic [XLEN-1:0]  rs1, rs2, rs3;
  exec_result_t     single_res, push_dat, head;
  logic             push, pop, accept;
  logic [FcntW-1:0] fifo_cnt;

  assign rs1 = registers_i[XLEN-1:0];
  assign rs2 = registers_i[2*XLEN-1:XLEN];

  generate
    if (NrRgprPorts >= 3) begin : g_rs3
      assign rs3 = registers_i[3*XLEN-1:2*XLEN];
    end else begin : g_no_rs3
      assign rs3 = '0;
    end
  endgenerate

  always_comb begin
    single_res        = '0;
    single_res.hartid = hartid_i;
    single_res.id     = id_i;
    single_res.rd     = rd_i;
    case (opcode_i)
      OP_ADD: begin
        single_res.data = rs1 + rs2;
        single_res.we   = 1'b1;
      end
      OP_DBL: begin
        single_res.data = {rs1[XLEN-2:0], 1'b0};
        single_res.we   = 1'b1;
      end
      OP_ADD3: begin
        single_res.data = rs1 + rs2 + rs3;
        single_res.we   = 1'b1;
      end
      default: ;
    endcase
  end

  // in_ready_o looks only at registered state, so a same-cycle pop cannot open a slot.
  assign in_ready_o = rst_ni && (state_q == ST_IDLE) && (fifo_cnt < FcntW'(FifoDepth));
  assign accept     = in_valid_i && in_ready_o;
  assign pop        = result_valid_o && result_ready_i;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mop_d    = mop_q;
    push     = 1'b0;
    push_dat = single_res;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (opcode_i == OP_ADD_MULTI) begin
            mop_d.a      = rs1;
            mop_d.b      = rs2;
            mop_d.hartid = hartid_i;
            mop_d.id     = id_i;
            mop_d.rd     = rd_i;
            cnt_d        = CntW'(MultiLatency - 2);
            state_d      = ST_BUSY;
          end else begin
            push = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          push            = 1'b1;
          push_dat.hartid = mop_q.hartid;
          push_dat.id     = mop_q.id;
          push_dat.data   = mop_q.a + mop_q.b;
          push_dat.rd     = mop_q.rd;
          push_dat.we     = 1'b1;
          state_d         = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mop_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mop_q   <= mop_d;
    end
  end

  copro_result_fifo #(
    .T     (exec_result_t),
    .Depth (FifoDepth)
  ) u_result_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .head_o     (head),
    .valid_o    (result_valid_o),
    .count_o    (fifo_cnt)
  );

  assign result_hartid_o = head.hartid;
  assign result_id_o     = head.id;
  assign result_data_o   = head.data;
  assign result_rd_o     = head.rd;
  assign result_we_o     = head.we;

endmodule

// File: tb/tb_copro_exec_unit.sv
// Directed and random checks of copro_exec_unit against an in-order scoreboard.
module tb_copro_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [63:0] regs;
  logic [0:0]  hartid;
  logic [2:0]  id;
  logic [4:0]  rd;
  logic        result_valid;
  logic        result_ready;
  logic [0:0]  result_hartid;
  logic [2:0]  result_id;
  logic [31:0] result_data;
  logic [4:0]  result_rd;
  logic        result_we;

  int errors = 0;
  int checks = 0;

  logic [63:0] exp_q [$];
  logic [63:0] prev_out;
  logic        stall_prev = 1'b0;
  logic        stress_done;

  always #5 clk = ~clk;

  copro_exec_unit dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .opcode_i        (opcode),
    .registers_i     (regs),
    .hartid_i        (hartid),
    .id_i            (id),
    .rd_i            (rd),
    .result_valid_o  (result_valid),
    .result_ready_i  (result_ready),
    .result_hartid_o (result_hartid),
    .result_id_o     (result_id),
    .result_data_o   (result_data),
    .result_rd_o     (result_rd),
    .result_we_o     (result_we)
  );

  function automatic logic [63:0] pack(input logic [0:0] h, input logic [2:0] i,
                                       input logic [31:0] d, input logic [4:0] r,
                                       input logic w);
    return 64'({h, i, d, r, w});
  endfunction

  // Reference behaviour per opcode, returned as {we, data}.
  function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      4'd1, 4'd3, 4'd4: return {1'b1, a + b};
      4'd2:             return {1'b1, a << 1};
      default:          return 33'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction and hold it until accepted; expectation queued on acceptance.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] i, input logic [4:0] r, input logic h,
                       input logic [31:0] exp_data, input logic exp_we);
    bit done = 0;
    in_valid = 1'b1;
    opcode   = op;
    regs     = {b, a};
    id       = i;
    rd       = r;
    hartid   = h;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(pack(h, i, exp_data, r, exp_we));
        done = 1;
      end
    end
    chk("issue_accepted", 64'(done), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    result_ready = 1'b1;
    repeat (n) step();
    result_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stable_while_stalled",
            {result_valid, pack(result_hartid, result_id, result_data, result_rd, result_we)},
            {1'b1, prev_out});
      end
      if (result_valid && result_ready) begin
        chk("result_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          chk("result_order",
              pack(result_hartid, result_id, result_data, result_rd, result_we),
              exp_q.pop_front());
        end
      end
      stall_prev = result_valid && !result_ready;
      prev_out   = pack(result_hartid, result_id, result_data, result_rd, result_we);
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; result_ready = 1'b0;
    opcode = '0; regs = '0; hartid = '0; id = '0; rd = '0; stress_done = 1'b0;
    step(); step();
    @(negedge clk);
    chk("reset_valid", 64'(result_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    chk("reset_outputs", pack(result_hartid, result_id, result_data, result_rd, result_we), 64'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(in_ready), 64'd1);
    step();

    // ADD 5+7 visible the cycle after acceptance
    issue(4'd1, 32'd5, 32'd7, 3'd2, 5'd10, 1'b0, 32'd12, 1'b1);
    @(negedge clk);
    chk("add_valid", 64'(result_valid), 64'd1);
    chk("add_fields", pack(result_hartid, result_id, result_data, result_rd, result_we),
        pack(1'b0, 3'd2, 32'd12, 5'd10, 1'b1));
    step();
    drain(2);

    // ADD_MULTI wraps to 1; busy for three cycles, visible on the fourth
    issue(4'd3, 32'hFFFF_FFFF, 32'd2, 3'd3, 5'd4, 1'b1, 32'd1, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("multi_busy_ready", 64'(in_ready), 64'd0);
      chk("multi_busy_valid", 64'(result_valid), 64'd0);
    end
    @(negedge clk);
    chk("multi_visible", {62'd0, result_valid, in_ready}, 64'd3);
    chk("multi_data", 64'(result_data), 64'd1);
    step();
    drain(2);

    // Fill the queue with four ADDs, the fifth must stall
    for (int k = 0; k < 4; k++) begin
      issue(4'd1, 32'(k), 32'd100, 3'(k), 5'(k + 1), 1'b0, 32'(k + 100), 1'b1);
    end
    in_valid = 1'b1; opcode = 4'd1; regs = {32'd100, 32'd4}; id = 3'd4; rd = 5'd5; hartid = 1'b0;
    @(negedge clk);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    step();
    result_ready = 1'b1;
    @(negedge clk);
    chk("no_bypass_on_pop", 64'(in_ready), 64'd0);
    step();
    result_ready = 1'b0;
    @(negedge clk);
    chk("ready_after_pop", 64'(in_ready), 64'd1);
    exp_q.push_back(pack(1'b0, 3'd4, 32'd104, 5'd5, 1'b1));
    step();
    in_valid = 1'b0;
    drain(6);
    @(negedge clk);
    chk("drained_queue", 64'(exp_q.size()), 64'd0);
    step();

    // ADD3 with two ports, then an unknown opcode
    result_ready = 1'b1;
    issue(4'd4, 32'd1, 32'd2, 3'd5, 5'd6, 1'b1, 32'd3, 1'b1);
    issue(4'd9, 32'd8, 32'd9, 3'd6, 5'd7, 1'b0, 32'd0, 1'b0);
    issue(4'd0, 32'd8, 32'd9, 3'd7, 5'd8, 1'b1, 32'd0, 1'b0);
    issue(4'd2, 32'h8000_0003, 32'd0, 3'd0, 5'd9, 1'b0, 32'd6, 1'b1);
    drain(3);

    // Reset while BUSY with two queued entries
    issue(4'd1, 32'd1, 32'd1, 3'd1, 5'd1, 1'b0, 32'd2, 1'b1);
    issue(4'd1, 32'd2, 32'd2, 3'd2, 5'd2, 1'b0, 32'd4, 1'b1);
    issue(4'd3, 32'd3, 32'd3, 3'd3, 5'd3, 1'b0, 32'd6, 1'b1);
    rst_n = 1'b0;
    exp_q.delete();
    step();
    @(negedge clk);
    chk("rst_busy_valid", 64'(result_valid), 64'd0);
    chk("rst_busy_ready_low", 64'(in_ready), 64'd0);
    step();
    rst_n = 1'b1;
    result_ready = 1'b1;
    @(negedge clk);
    chk("rst_busy_ready_high", 64'(in_ready), 64'd1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("no_stale_result", 64'(result_valid), 64'd0);
    end
    step();
    result_ready = 1'b0;

    // Random valid/ready stress
    fork
      begin
        for (int k = 0; k < 60; k++) begin
          logic [3:0]  op;
          logic [31:0] a, b;
          logic [32:0] m;
          op = 4'($urandom_range(0, 15));
          if ($urandom_range(0, 2) == 0) op = 4'd3;
          a  = $urandom;
          b  = $urandom;
          m  = model(op, a, b);
          issue(op, a, b, 3'(k), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                m[31:0], m[32]);
          repeat ($urandom_range(0, 2)) step();
        end
        stress_done = 1'b1;
      end
      begin
        while (!stress_done) begin
          @(posedge clk);
          #1;
          result_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    result_ready = 1'b1;
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) step();
    @(negedge clk);
    chk("stress_all_delivered", 64'(exp_q.size()), 64'd0);
    chk("stress_queue_empty", 64'(result_valid), 64'd0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/copro_exec_unit.md
# copro_exec_unit

Execution stage of the CV-X-IF example coprocessor, sitting directly downstream of the instruction decoder. Accepts one decoded instruction per cycle (opcode, source operands, hart ID, instruction ID, rd), computes the result in a single-cycle or multi-cycle datapath, and queues results in order. The queue drives the CV-X-IF result handshake back to the core.

## Interface
Parameters:
- XLEN, 32: operand/result width.
- NrRgprPorts, 2: source operand ports (2 or 3).
- HartIdWidth, 1: hart ID width.
- IdWidth, 3: instruction ID width.
- FifoDepth, 4: result queue entries (power of two, ≥2).
- MultiLatency, 4: acceptance-to-visible latency of ADD_MULTI (≥2).

Ports (one clock; reset is synchronous and active-low):
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- in_valid_i  in  1  decoded instruction valid.
- in_ready_o  out  1  unit can accept.
- opcode_i  in  4  decoded opcode.
- registers_i  in  NrRgprPorts*XLEN  source operands; rs1 at [XLEN-1:0].
- hartid_i  in  HartIdWidth  issuing hart.
- id_i  in  IdWidth  instruction ID.
- rd_i  in  5  destination register.
- result_valid_o  out  1  queue head valid.
- result_ready_i  in  1  core accepts result.
- result_hartid_o  out  HartIdWidth  head hart ID.
- result_id_o  out  IdWidth  head instruction ID.
- result_data_o  out  XLEN  head data.
- result_rd_o  out  5  head rd.
- result_we_o  out  1  head register-write enable.

## Operation
- Opcodes: 0 NOP (data 0, we=0); 1 ADD rs1+rs2; 2 DBL rs1<<1; 3 ADD_MULTI rs1+rs2 via the multi-cycle path; 4 ADD3 rs1+rs2+rs3, with rs3 treated as 0 when NrRgprPorts==2; 5–15 unknown (data 0, we=0). Opcodes 1–4 set we=1. All arithmetic is modulo 2^XLEN and carries are dropped.
- Every accepted instruction produces exactly one result, including NOP and unknown opcodes.
- Transfer occurs when in_valid_i && in_ready_o.
- FSM states:
  - IDLE: single-cycle ops are pushed into the queue at the accepting edge. ADD_MULTI latches its operands, hartid, id and rd, loads the counter with MultiLatency-2, and enters BUSY.
  - BUSY: counter decrements each cycle. At counter==0 the result is pushed and the FSM returns to IDLE.
- in_ready_o = rst_ni && state==IDLE && count<FifoDepth.
  - A BUSY op always has a reserved queue slot. A push is made only when count<FifoDepth.
  - Pops in the same cycle do not raise in_ready_o (no full-bypass).
- Queue: in-order circular buffer with a count of log2(FifoDepth)+1 bits. Pointers wrap at FifoDepth.
  - Simultaneous push and pop leaves count unchanged.
  - A pop on empty is impossible, since result_valid_o=0.
- result_* outputs show the head entry. Pop occurs when result_valid_o && result_ready_i.
- result_* must stay stable while result_valid_o && !result_ready_i.

## Timing
- Reset (synchronous, rst_ni low at a clock edge):
  - FSM goes to IDLE, counter to 0, pointers and count to 0, storage to 0. An in-flight ADD_MULTI is discarded.
  - After reset: result_valid_o=0, all result_* = 0, in_ready_o=0 while rst_ni is low.
- Single-cycle op accepted at edge t: result_valid_o high from cycle t+1 if the queue was empty.
- ADD_MULTI accepted at edge t: pushed at edge t+MultiLatency-1, visible from t+MultiLatency. in_ready_o is low for cycles t+1 through t+MultiLatency-1.
- in_ready_o is combinational from registered state only. It does not depend on in_valid_i or result_ready_i.
- Back-to-back single-cycle ops sustain one per cycle while the queue is not full.

## Structure
- Package copro_pkg holds:
  - opcode enum (NOP, ADD, DBL, ADD_MULTI, ADD3);
  - result struct {hartid, id, data, rd, we};
  - FSM state enum.
- Sub-module copro_result_fifo, generic over the result struct, holds the in-order queue. The top level contains the FSM, counter and datapath.

## Test plan
- Reset, then ADD with rs1=5, rs2=7, id=2, rd=10 -> next cycle result_valid_o=1, data=12, we=1, id=2, rd=10.
- ADD_MULTI with 0xFFFFFFFF+2, MultiLatency=4, accepted at t -> in_ready_o=0 for t+1..t+3; result data=1 appears at t+4.
- Five back-to-back ADDs with result_ready_i=0 and FifoDepth=4 -> four accepted and in_ready_o drops. Pulsing result_ready_i for one cycle pops id0, and in_ready_o rises the following cycle.
- ADD3 with NrRgprPorts=2 and rs1=1, rs2=2 -> data=3. Opcode 9 -> data=0, we=0, result still produced.
- rst_ni low during BUSY with two queued entries -> after the edge result_valid_o=0 and in_ready_o=1 once rst_ni is high; no stale result emerges.
- Random valid/ready stress -> results leave in acceptance order, one per accepted instruction, stable while stalled.
